// File: rtl/lsu_pkg.sv
// Shared types, defaults and helpers for the load/store controller.
`timescale 1ns/1ps
package lsu_pkg;

    // Controller states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_e;

    // Default parameter values
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_OFF_W      = 4;
    localparam int DEF_ADDR_SHIFT = 1;
    localparam int DEF_TIMEOUT    = 15;

    // Internal width used for address arithmetic before truncation to ADDR_W
    localparam int EA_W = 32;

    // Scale an already sign-extended offset by the access granularity
    function automatic logic [EA_W-1:0] sext_shift(input logic signed [EA_W-1:0] off,
                                                   input int                     shift);
        logic signed [EA_W-1:0] scaled;
        scaled = off <<< shift;
        return scaled;
    endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Combinational effective-address generator: base + (sext(offset) << ADDR_SHIFT),
// wrapping modulo 2^ADDR_W. With LSU_ALIGN_CHECK_EN the base keeps its low bits
// and misalign reports a sum that is not a multiple of 2^ADDR_SHIFT; otherwise
// the base low bits are cleared and misalign is always 0.
`timescale 1ns/1ps
module lsu_addr_gen
    import lsu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int OFF_W      = DEF_OFF_W,
    parameter int ADDR_SHIFT = DEF_ADDR_SHIFT
) (
    input  logic [DATA_W-1:0] rs_data,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] ea,
    output logic              misalign
);

    logic signed [EA_W-1:0] off_ext;
    logic [EA_W-1:0]        base_full;
    logic [EA_W-1:0]        base_eff;
    logic [EA_W-1:0]        low_mask;
    logic [EA_W-1:0]        sum_full;
    logic                   unused_sum;

    // Extend, scale and add; the upper sum bits fall away on truncation
    always_comb begin
        off_ext   = EA_W'($signed(offset));
        base_full = EA_W'(rs_data);
        low_mask  = (EA_W'(1) << ADDR_SHIFT) - EA_W'(1);
`ifdef LSU_ALIGN_CHECK_EN
        base_eff  = base_full;
`else
        base_eff  = base_full & ~low_mask;
`endif
        sum_full  = base_eff + sext_shift(off_ext, ADDR_SHIFT);
        ea        = sum_full[ADDR_W-1:0];
        misalign  = |(sum_full & low_mask);
    end

    assign unused_sum = ^sum_full;

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a multi-cycle data memory.
// Accepts one request while idle, holds the memory request until mem_ack or a
// TIMEOUT-cycle watchdog expires, and stalls the pipeline meanwhile.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned requests are refused with an
// err pulse instead of having their low address bits masked.
`timescale 1ns/1ps
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int OFF_W      = DEF_OFF_W,
    parameter int ADDR_SHIFT = DEF_ADDR_SHIFT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [OFF_W-1:0]  offset,
    output logic              req_ready,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              err
);

    localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ld_valid_q,  ld_valid_d;
    logic [DATA_W-1:0] ld_data_q,   ld_data_d;
    logic              err_q,       err_d;

    logic [ADDR_W-1:0] ea;
    logic              misalign;
    logic              align_fault;

    lsu_addr_gen #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .OFF_W      (OFF_W),
        .ADDR_SHIFT (ADDR_SHIFT)
    ) u_addr_gen (
        .rs_data  (rs_data),
        .offset   (offset),
        .ea       (ea),
        .misalign (misalign)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign align_fault = misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign align_fault     = 1'b0;
`endif

    // Next-state and next-output decode; pulses default low every cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (align_fault) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr_d  = ea;
                        mem_wr_d    = req_wr;
                        mem_wdata_d = rt_data;
                        cnt_d       = '0;
                        mem_en_d    = 1'b1;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (!mem_wr_q) begin
                        ld_data_d  = mem_rdata;
                        ld_valid_d = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d    = 1'b1;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, watchdog counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = req_valid & ~req_ready;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed scenarios plus randomized operations
// against a behavioural address/memory model. Honours LSU_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [3:0]  offset;
    logic        req_ready;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(
        .DATA_W(16), .ADDR_W(16), .OFF_W(4), .ADDR_SHIFT(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .rs_data(rs_data), .rt_data(rt_data), .offset(offset),
        .req_ready(req_ready), .stall(stall), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .ld_valid(ld_valid), .ld_data(ld_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          en_cycles;
        int          addr_changes;
        int          stall_bad;
        int          stray;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic        ready_at_accept;
        logic        ldv;
        logic [15:0] ldd;
        logic        errp;
        logic        ready_end;
        logic        en_end;
        logic        wr_end;
    } obs_t;

    typedef struct {
        int          en_cycles;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic        ldv;
        logic [15:0] ldd;
        logic        err;
    } exp_t;

    // Memory device contents (indexed by what the DUT presents) and reference copy
    logic [15:0] dmem [bit [15:0]];
    logic [15:0] rmem [bit [15:0]];
    logic [15:0] last_ld = 16'h0000;

    function automatic logic [15:0] fill_pattern(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] model_ea(input logic [15:0] rs, input logic [3:0] off);
        int base;
        int o4;
        o4 = int'(off);
        if (o4 >= 8) o4 = o4 - 16;
`ifdef LSU_ALIGN_CHECK_EN
        base = int'(rs);
`else
        base = (int'(rs) / 2) * 2;
`endif
        return 16'((base + o4 * 2) & 32'hFFFF);
    endfunction

    function automatic bit model_misalign(input logic [15:0] rs);
`ifdef LSU_ALIGN_CHECK_EN
        return (int'(rs) % 2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic wr, input logic [15:0] rs, input logic [15:0] rt,
                              input logic [3:0] off, input int ack_delay, output exp_t e);
        logic [15:0] ea;
        ea = model_ea(rs, off);
        e = '{default: 0};
        e.ldd = last_ld;
        if (model_misalign(rs)) begin
            e.err = 1'b1;
        end else begin
            e.addr = ea;
            e.wdata = rt;
            e.wr = wr;
            if (ack_delay < 0 || ack_delay >= TIMEOUT) begin
                e.en_cycles = TIMEOUT;
                e.err = 1'b1;
            end else begin
                e.en_cycles = ack_delay + 1;
                if (wr) begin
                    rmem[ea] = rt;
                end else begin
                    e.ldv = 1'b1;
                    e.ldd = rmem.exists(ea) ? rmem[ea] : fill_pattern(ea);
                    last_ld = e.ldd;
                end
            end
        end
    endtask

    // Present one request from an idle cycle, act as the memory, and record what happens
    task automatic run_op(input logic wr, input logic [15:0] rs, input logic [15:0] rt,
                          input logic [3:0] off, input int ack_delay, output obs_t o);
        int cyc;
        o = '{default: 0};
        req_valid = 1'b1; req_wr = wr; rs_data = rs; rt_data = rt; offset = off;
        o.ready_at_accept = req_ready;
        @(posedge clk); #1;
        cyc = 0;
        while (mem_en === 1'b1 && cyc < TIMEOUT + 5) begin
            if (cyc == 0) begin
                o.addr = mem_addr; o.wdata = mem_wdata; o.wr = mem_wr;
            end else if (mem_addr !== o.addr || mem_wdata !== o.wdata || mem_wr !== o.wr) begin
                o.addr_changes++;
            end
            if (stall !== 1'b1) o.stall_bad++;
            if (ld_valid !== 1'b0 || err !== 1'b0) o.stray++;
            o.en_cycles++;
            if (ack_delay >= 0 && cyc == ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : fill_pattern(mem_addr);
                if (mem_wr === 1'b1) dmem[mem_addr] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 16'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0;
        req_valid = 1'b0;
        o.ldv = ld_valid; o.ldd = ld_data; o.errp = err;
        o.ready_end = req_ready; o.en_end = mem_en; o.wr_end = mem_wr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; rs_data = '0; rt_data = '0;
        offset = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_en, mem_wr, ld_valid, err, stall} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got en/wr/ldv/err/stall=%b required 00000",
                     {mem_en, mem_wr, ld_valid, err, stall});
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || ld_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h ld=%h required zeros",
                     mem_addr, mem_wdata, ld_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        last_ld = 16'h0;
    endtask

    task automatic test_zero_wait_store();
        obs_t o;
        exp_t e;
        model_step(1'b1, 16'h0000, 16'hBEEF, 4'h0, 0, e);
        run_op(1'b1, 16'h0000, 16'hBEEF, 4'h0, 0, o);
        checks++;
        if (o.en_cycles != 1 || o.addr !== 16'h0000 || o.wdata !== 16'hBEEF || o.wr !== 1'b1) begin
            errors++;
            $display("FAIL store_zw: got cyc=%0d addr=%h wdata=%h wr=%b required 1/0000/beef/1",
                     o.en_cycles, o.addr, o.wdata, o.wr);
        end
        checks++;
        if (o.ldv !== 1'b0 || o.ready_end !== 1'b1 || o.wr_end !== 1'b0 || o.errp !== 1'b0) begin
            errors++;
            $display("FAIL store_zw_end: got ldv=%b ready=%b wr=%b err=%b required 0/1/0/0",
                     o.ldv, o.ready_end, o.wr_end, o.errp);
        end
    endtask

    task automatic test_offset_load();
        obs_t o;
        exp_t e;
        model_step(1'b1, 16'h0000, 16'hDEAD, 4'h1, 0, e);
        run_op(1'b1, 16'h0000, 16'hDEAD, 4'h1, 0, o);
        checks++;
        if (o.addr !== 16'h0002) begin
            errors++;
            $display("FAIL off_store_addr: got %h required 0002", o.addr);
        end
        model_step(1'b0, 16'h0001, 16'h1234, 4'h1, 0, e);
        run_op(1'b0, 16'h0001, 16'h1234, 4'h1, 0, o);
        checks++;
        if (o.addr !== e.addr || o.en_cycles != e.en_cycles || o.errp !== e.err) begin
            errors++;
            $display("FAIL off_load_addr: got addr=%h cyc=%0d err=%b required %h/%0d/%b",
                     o.addr, o.en_cycles, o.errp, e.addr, e.en_cycles, e.err);
        end
        checks++;
        if (o.ldv !== e.ldv || o.ldd !== e.ldd) begin
            errors++;
            $display("FAIL off_load_data: got ldv=%b ld=%h required %b/%h", o.ldv, o.ldd, e.ldv, e.ldd);
        end
    endtask

    task automatic test_negative_wrap();
        obs_t o;
        exp_t e;
        model_step(1'b0, 16'h0000, 16'h0000, 4'hF, 0, e);
        run_op(1'b0, 16'h0000, 16'h0000, 4'hF, 0, o);
        checks++;
        if (o.addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL neg_wrap_addr: got %h required fffe", o.addr);
        end
        checks++;
        if (o.ldd !== e.ldd || o.ldv !== 1'b1) begin
            errors++;
            $display("FAIL neg_wrap_data: got ldv=%b ld=%h required 1/%h", o.ldv, o.ldd, e.ldd);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        exp_t e;
        model_step(1'b0, 16'h0010, 16'h7777, 4'h3, 3, e);
        run_op(1'b0, 16'h0010, 16'h7777, 4'h3, 3, o);
        checks++;
        if (o.en_cycles != 4 || o.addr_changes != 0 || o.stall_bad != 0 || o.stray != 0) begin
            errors++;
            $display("FAIL wait_hold: got cyc=%0d changes=%0d nostall=%0d stray=%0d required 4/0/0/0",
                     o.en_cycles, o.addr_changes, o.stall_bad, o.stray);
        end
        checks++;
        if (o.ldv !== 1'b1 || o.ldd !== e.ldd || o.addr !== e.addr) begin
            errors++;
            $display("FAIL wait_result: got ldv=%b ld=%h addr=%h required 1/%h/%h",
                     o.ldv, o.ldd, o.addr, e.ldd, e.addr);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        model_step(1'b0, 16'h0020, 16'h0000, 4'h0, -1, e);
        run_op(1'b0, 16'h0020, 16'h0000, 4'h0, -1, o);
        checks++;
        if (o.en_cycles != TIMEOUT || o.errp !== 1'b1 || o.en_end !== 1'b0 || o.ldv !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got cyc=%0d err=%b en=%b ldv=%b required %0d/1/0/0",
                     o.en_cycles, o.errp, o.en_end, o.ldv, TIMEOUT);
        end
        model_step(1'b0, 16'h0022, 16'h0000, 4'h0, TIMEOUT - 1, e);
        run_op(1'b0, 16'h0022, 16'h0000, 4'h0, TIMEOUT - 1, o);
        checks++;
        if (o.ready_at_accept !== 1'b1 || o.en_cycles != TIMEOUT || o.errp !== 1'b0 ||
            o.ldv !== 1'b1 || o.ldd !== e.ldd || o.stray != 0) begin
            errors++;
            $display("FAIL ack_last_cycle: got rdy=%b cyc=%0d err=%b ldv=%b ld=%h required 1/%0d/0/1/%h",
                     o.ready_at_accept, o.en_cycles, o.errp, o.ldv, o.ldd, TIMEOUT, e.ldd);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        model_step(1'b0, 16'h0002, 16'h0000, 4'h0, 0, e);
        run_op(1'b0, 16'h0002, 16'h0000, 4'h0, 0, o);
        model_step(1'b0, 16'h0100, 16'h0000, 4'h2, 0, e);
        run_op(1'b0, 16'h0100, 16'h0000, 4'h2, 0, o);
        checks++;
        if (o.ready_at_accept !== 1'b1 || o.stray != 0 || o.en_cycles != 1 || o.ldd !== e.ldd) begin
            errors++;
            $display("FAIL back_to_back: got rdy=%b stray=%0d cyc=%0d ld=%h required 1/0/1/%h",
                     o.ready_at_accept, o.stray, o.en_cycles, o.ldd, e.ldd);
        end
        @(posedge clk); #1;
        checks++;
        if (ld_valid !== 1'b0 || ld_data !== e.ldd) begin
            errors++;
            $display("FAIL ld_pulse_hold: got ldv=%b ld=%h required 0/%h", ld_valid, ld_data, e.ldd);
        end
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1; req_wr = 1'b0; rs_data = 16'h0004; rt_data = 16'h0; offset = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        @(posedge clk); #1;
        checks++;
        if (mem_en !== 1'b0 || req_ready !== 1'b1 || ld_valid !== 1'b0 || err !== 1'b0 ||
            mem_addr !== 16'h0 || ld_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: got en=%b rdy=%b ldv=%b err=%b addr=%h ld=%h required 0/1/0/0/0/0",
                     mem_en, req_ready, ld_valid, err, mem_addr, ld_data);
        end
        rst_n = 1'b1;
        last_ld = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ld_valid !== 1'b0 || err !== 1'b0 || mem_en !== 1'b0 || ld_data !== 16'h0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got ldv=%b err=%b en=%b ld=%h required 0/0/0/0",
                     ld_valid, err, mem_en, ld_data);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_alignment();
        obs_t o;
        exp_t e;
        model_step(1'b0, 16'h0001, 16'h0000, 4'h0, 0, e);
        run_op(1'b0, 16'h0001, 16'h0000, 4'h0, 0, o);
        checks++;
        if (o.en_cycles != e.en_cycles || o.errp !== e.err || o.addr !== e.addr ||
            o.ready_end !== 1'b1 || o.en_end !== 1'b0 || o.ldv !== e.ldv) begin
            errors++;
            $display("FAIL align: got cyc=%0d err=%b addr=%h rdy=%b ldv=%b required %0d/%b/%h/1/%b",
                     o.en_cycles, o.errp, o.addr, o.ready_end, o.ldv, e.en_cycles, e.err, e.addr, e.ldv);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic        wr;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [3:0]  off;
        int          dly;
        int          r;
        for (int i = 0; i < 60; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            rt  = 16'($urandom);
            off = 4'($urandom);
            r   = $urandom_range(0, 9);
            dly = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            model_step(wr, rs, rt, off, dly, e);
            run_op(wr, rs, rt, off, dly, o);
            checks++;
            if (o.en_cycles != e.en_cycles || o.addr !== e.addr || o.wdata !== e.wdata ||
                o.wr !== e.wr || o.ldv !== e.ldv || o.ldd !== e.ldd || o.errp !== e.err) begin
                errors++;
                $display("FAIL rand_op[%0d]: got cyc=%0d addr=%h wd=%h wr=%b ldv=%b ld=%h err=%b required %0d/%h/%h/%b/%b/%h/%b",
                         i, o.en_cycles, o.addr, o.wdata, o.wr, o.ldv, o.ldd, o.errp,
                         e.en_cycles, e.addr, e.wdata, e.wr, e.ldv, e.ldd, e.err);
            end
            checks++;
            if (o.addr_changes != 0 || o.stall_bad != 0 || o.stray != 0 || o.ready_at_accept !== 1'b1 ||
                o.ready_end !== 1'b1 || o.en_end !== 1'b0 || o.wr_end !== 1'b0) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got chg=%0d nostall=%0d stray=%0d rdy0=%b rdy=%b en=%b wr=%b required 0/0/0/1/1/0/0",
                         i, o.addr_changes, o.stall_bad, o.stray, o.ready_at_accept,
                         o.ready_end, o.en_end, o.wr_end);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_store();
        test_offset_load();
        test_negative_wrap();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_alignment();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store controller; the successor to the single-cycle data-memory address block.
- Computes the effective address from base register + sign-extended, scaled offset.
- Drives a multi-cycle data memory through a request/acknowledge handshake, with a timeout watchdog.
- Sits between the pipeline MEM stage and the data memory; stalls the pipeline while an access is outstanding.

Parameters:
- DATA_W, 16, data and register width.
- ADDR_W, 16, memory address width.
- OFF_W, 4, immediate offset width (two's complement).
- ADDR_SHIFT, 1, offset left-shift and alignment granularity (1 = 16-bit words in a byte-addressed space).
- TIMEOUT, 15, max cycles in ACCESS waiting for mem_ack (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline presents a memory op.
- req_wr  in  1  1 = store, 0 = load.
- rs_data  in  DATA_W  base register value.
- rt_data  in  DATA_W  store data.
- offset  in  OFF_W  signed immediate.
- req_ready  out  1  controller idle; a request is accepted this cycle.
- stall  out  1  req_valid & ~req_ready.
- mem_en  out  1  memory request strobe.
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- ld_valid  out  1  one-cycle pulse: ld_data holds load result.
- ld_data  out  DATA_W  last load result (held).
- err  out  1  one-cycle pulse: timeout (or misalignment, see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, counter=0.
  - Outputs: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, ld_valid=0, ld_data=0, err=0, req_ready=1 in the next cycle.
  - Reset mid-access abandons the access; no ld_valid or err is produced.
- Address:
  - ea = (rs_data with low ADDR_SHIFT bits cleared) + (sext(offset) << ADDR_SHIFT).
  - Truncated to ADDR_W; wraps modulo 2^ADDR_W with no flag.
- State IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: register ea, req_wr and rt_data into mem_addr, mem_wr and mem_wdata; counter=0; go to ACCESS.
  - mem_ack in IDLE is ignored.
- State ACCESS:
  - mem_en=1; mem_addr, mem_wr and mem_wdata held stable; req_ready=0.
  - Edge with mem_ack=1:
    - Load: ld_data<=mem_rdata, ld_valid<=1.
    - Store: no ld_valid.
    - In both cases: mem_en<=0, go to IDLE.
  - Edge with mem_ack=0:
    - counter increments.
    - If counter==TIMEOUT-1: err<=1, mem_en<=0, go to IDLE.
  - mem_ack on the final timeout cycle takes priority over timeout.
- Latency:
  - Request accepted at edge N; mem_en high from N+1.
  - Zero-wait memory acks in cycle N+1; ld_valid is high in cycle N+2, the same cycle req_ready returns to 1.
  - Minimum issue interval is 2 cycles.
- ld_valid and err are single-cycle pulses. ld_data holds until the next load completes.
- mem_wr is 0 whenever mem_en=0.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - The base is not masked.
  - If the unmasked sum has any of the low ADDR_SHIFT bits set, the request is accepted but no memory access is issued.
  - err pulses at N+1, the controller stays in IDLE, and it is ready again at N+1.
- Undefined: low bits are silently masked as described above; err signals only timeouts.

Decomposition:
- Package lsu_pkg:
  - State enum: IDLE, ACCESS.
  - Function sext_shift(offset, shift).
  - Default parameter constants.
- Sub-module lsu_addr_gen: combinational effective-address adder, parametrised by DATA_W, ADDR_W, OFF_W, ADDR_SHIFT; also produces the misalign flag.
- FSM, counter and output registers live in lsu_mem_ctrl.

Test Plan:
- Store with zero-wait memory.
  - Stimulus: rs=0x0000, off=0, rt=0xBEEF, wr=1, memory acks in the first ACCESS cycle.
  - Response: mem_en=1, mem_addr=0x0000, mem_wdata=0xBEEF for exactly one cycle; no ld_valid; req_ready back after 2 cycles.
- Positive offset, then load of the same word.
  - Stimulus: store 0xDEAD with rs=0, off=1; then load with rs=0x0001, off=1.
  - Response: mem_addr=0x0002 for both; ld_valid pulses once with ld_data=0xDEAD.
- Negative offset and wrap.
  - Stimulus: load with rs=0x0000, off=4'hF.
  - Response: mem_addr=0xFFFE.
- Memory wait states and stall.
  - Stimulus: ack delayed 3 cycles with req_valid held high.
  - Response: addr and data stable for 4 cycles; stall=1 throughout; ld_valid one cycle after ack.
- Timeout.
  - Stimulus: no ack, TIMEOUT=15.
  - Response: err pulses after 15 ACCESS cycles; mem_en drops; the next request is accepted.
- Reset mid-ACCESS, then alignment check.
  - Stimulus: rst_n=0 for 1 cycle during ACCESS.
  - Response: mem_en=0 and IDLE next cycle; no ld_valid or err.
  - With LSU_ALIGN_CHECK_EN defined: rs=0x0001, off=0 → err pulse, mem_en stays 0.
